// File: rtl/div_s_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : div_s_defs                                                      |
// | Purpose  : state encoding and constants shared by the div_s datapath.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package div_s_defs;

  localparam int          ITERATIONS = 15;
  localparam logic [15:0] MAX_16     = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/div_s_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_s_step                                                      |
// | Purpose  : one combinational restoring-division iteration.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module div_s_step (
  input  logic [31:0] l_num,
  input  logic [31:0] l_denom,
  input  logic [15:0] q,
  output logic [31:0] l_num_next,
  output logic [15:0] q_next
);

  logic [31:0] num_sh;
  logic [15:0] q_sh;

  always_comb begin
    num_sh = l_num << 1;
    q_sh   = q << 1;
    // Both operands are zero-extended 16-bit values, so the compare never wraps.
    if (num_sh >= l_denom) begin
      l_num_next = num_sh - l_denom;
      q_next     = q_sh | 16'd1;
    end else begin
      l_num_next = num_sh;
      q_next     = q_sh;
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_s_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : div_s_seq                                                       |
// | Purpose  : sequential G.729 div_s (Q15 var1/var2), one quotient bit/clock. |
// |            Define DIV_S_ERR_EN to flag illegal operands on err.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module div_s_seq #(
  parameter int ITERATIONS = div_s_defs::ITERATIONS,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic [15:0] var1,
  input  logic [15:0] var2,
  output logic [15:0] out,
  output logic        done,
  output logic        err
);

  import div_s_defs::*;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        num_q, num_d;
  logic [31:0]        den_q, den_d;
  logic [15:0]        quo_q, quo_d;
  logic [15:0]        out_q, out_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [31:0]        step_num;
  logic [15:0]        step_q;
  logic               illegal;

`ifdef DIV_S_ERR_EN
  assign illegal = var1[15] || var2[15] || (var2 == 16'd0) ||
                   ($signed(var1) > $signed(var2));
`else
  assign illegal = 1'b0;
`endif

  div_s_step u_step (
    .l_num      (num_q),
    .l_denom    (den_q),
    .q          (quo_q),
    .l_num_next (step_num),
    .q_next     (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    den_d   = den_q;
    quo_d   = quo_q;
    out_d   = out_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (ready) begin
          num_d = {16'd0, var1};
          den_d = {16'd0, var2};
          quo_d = '0;
          cnt_d = '0;
          err_d = 1'b0;
          // Special cases answer immediately; priority illegal > equal > zero.
          if (illegal) begin
            out_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (var1 == var2) begin
            out_d   = MAX_16;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (var1 == 16'd0) begin
            out_d   = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        num_d = step_num;
        quo_d = step_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
          out_d   = step_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      quo_q   <= quo_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: doc/div_s_seq.md
Name: div_s_seq

Overview:
- Sequential responder for the G.729 `div_s` basic operator: fractional Q15 division `var1/var2`, with `0 <= var1 <= var2` and `var2 > 0`.
- Serves the math-unit side of the ready/done handshake that the DSP-function FSMs (Inv_sqrt and similar) use to drive multi-cycle operators such as norm_l and L_shl.
- Produces a bit-exact ITU result using 15 restoring-division iterations, one per clock.

Parameters:
- ITERATIONS, 15: number of quotient bits generated, one per RUN cycle. Must stay 15 for ITU bit-exactness; exists for bench scaling only.
- CNT_W, 4: iteration counter width. Requires 2^CNT_W > ITERATIONS.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- ready  in  1  request from the initiating FSM; sampled only in IDLE
- var1  in  16  numerator, signed Q15
- var2  in  16  denominator, signed Q15
- out  out  16  quotient, Q15
- done  out  1  one-cycle completion strobe; `out` is valid while it is high
- err  out  1  illegal-operand flag, valid with `done` (see Optional Feature)

Behaviour:
- Reset:
  - Sampled on the rising clk edge while `reset == 0`.
  - Forces state IDLE, `out = 0`, `done = 0`, `err = 0`, counter 0, internal num/denom registers 0.
  - Reset mid-operation aborts the division. No `done` is produced for the aborted request.
- States: IDLE, RUN, DONE. Binary encoding, 2 bits.
- IDLE, `ready == 1` at edge E0:
  - Latch `L_num = var1` and `L_denom = var2`, both zero-extended to 32 bits.
  - Clear the quotient and the counter.
  - Next state:
    - `var1 == var2`: `out <= 16'h7FFF`, go to DONE.
    - `var1 == 0`: `out <= 0`, go to DONE.
    - Illegal operands with DIV_S_ERR_EN defined: `out <= 0`, `err <= 1`, go to DONE.
    - Otherwise: go to RUN.
  - Special-case priority: illegal > equal > zero.
- RUN, one edge per iteration:
  - `q <= q << 1`, `L_num <= L_num << 1`.
  - If shifted `L_num >= L_denom`: subtract `L_denom` and set `q[0] = 1`.
  - The compare is unsigned 32-bit and cannot overflow.
  - The counter increments each edge. At the edge completing iteration ITERATIONS: `out <= q_next`, go to DONE.
- DONE: `done = 1` for exactly one cycle, then IDLE unconditionally.
- Latency, measured from E0:
  - Special cases: `done` is high in the cycle after E0.
  - General case: `done` is high in the cycle after edge E0+15.
- Holding:
  - `out` and `err` hold until the next request is captured. `err` clears at capture.
  - `ready` is ignored in RUN and DONE; operand changes during RUN are ignored.
- Back-to-back: if `ready` stays high, a new request is captured at the first IDLE edge after DONE. The initiator must drop `ready` on seeing `done` if it wants a single operation.
- Result: general-case result equals `floor(var1 * 32768 / var2)`, truncated to 15 bits; bit 15 of `out` is always 0.

Optional Feature:
- Macro: DIV_S_ERR_EN.
- Defined:
  - `var1 < 0`, `var2 <= 0`, or `var1 > var2` is detected at capture.
  - Response: `out = 0`, `err = 1`, `done` in the next cycle (special-case latency).
- Undefined:
  - No operand checking; `err` is tied to 0.
  - Illegal operands run the normal 15 iterations on the zero-extended values. The result is deterministic but is not ITU-defined.

Decomposition:
- Shared include/package `div_s_defs`:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Constants `MAX_16 = 16'h7FFF` and ITERATIONS.
- Sub-module `div_s_step`:
  - One combinational restoring iteration.
  - Inputs: `L_num`, `L_denom`, `q`. Outputs: next `L_num`, next `q`.
  - Instantiated once in the datapath.

Test Plan:
- Reset low during RUN (third iteration), then release with `ready = 0` -> `done` never pulses, `out = 0`, state IDLE. Next request (`var1 = 16'h1000`, `var2 = 16'h4000`) -> `out = 16'h2000` 15 edges after capture.
- `var1 = 3`, `var2 = 7` -> `out = 16'h36DB`; `done` high for exactly one cycle after edge E0+15.
- `var1 = 16'h3000`, `var2 = 16'h3000` -> `out = 16'h7FFF`, `done` in the cycle after E0. Then `var1 = 0`, `var2 = 5` -> `out = 0`, same latency.
- `ready` held high continuously with `var1 = 1`, `var2 = 2` -> `out = 16'h4000` each time, `done` pulses every 17 cycles. Operands changed mid-RUN are not reflected in the current result.
- `var1 = 16'h4000`, `var2 = 16'h7FFF` -> `out = 16'h4000`.
- With DIV_S_ERR_EN: `var1 = 5`, `var2 = 3` -> `done` the cycle after E0, `err = 1`, `out = 0`. Next legal request clears `err`. Without the macro, `err` stays 0.
